// File: rtl/sdram_responder_if.sv
// Single-access SDR SDRAM pin bundle between a controller (master)
// and a memory device or emulator (slave).
interface sdram_responder_if;
    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [11:0] sd_addr;
    logic [1:0]  sd_ba;
    logic [1:0]  sd_dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output sd_cs, sd_ras, sd_cas, sd_we,
        output sd_addr, sd_ba, sd_dqm, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  sd_cs, sd_ras, sd_cas, sd_we,
        input  sd_addr, sd_ba, sd_dqm, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: decodes the command bus, tracks banks and
// mode, and serves single-word accesses from block RAM with CAS latency.
module sdram_responder #(
    parameter int ROW_USED     = 2,
    parameter int INIT_REFRESH = 2
) (
    input  logic               clk,
    input  logic               reset,
    sdram_responder_if.slave   bus,
    output logic [11:0]        mode_reg,
    output logic               initialized,
    output logic [15:0]        refresh_count,
    output logic               err
);
    localparam int AW = 2 + ROW_USED + 8;
    localparam logic [3:0] INIT_MIN = 4'(INIT_REFRESH);

    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101
    } cmd_t;

    logic [3:0]    cmd;
    logic [1:0]    bank;
    logic          a10;
    logic [3:0]    open_q;
    logic [11:0]   row_q [4];
    logic          pre_seen;
    logic [3:0]    init_cnt;

    logic          s1_v;
    logic          s1_cl3;
    logic [1:0]    s1_dqm;
    logic          s2_v;
    logic [15:0]   s2_data;
    logic [7:0]    rd_hi;
    logic [7:0]    rd_lo;
    logic [15:0]   s1_word;

    logic [7:0]    mem_hi [2**AW];
    logic [7:0]    mem_lo [2**AW];
    logic [AW-1:0] idx;

    logic          is_act;
    logic          is_rd;
    logic          is_wr;
    logic          is_pre;
    logic          is_ref;
    logic          is_lmr;
    logic          bank_open;
    logic          cl_ok;
    logic          do_act;
    logic          do_rd;
    logic          do_wr;
    logic          err_set;

    assign cmd  = {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we};
    assign bank = bus.sd_ba;
    assign a10  = bus.sd_addr[10];
    assign idx  = {bank, row_q[bank][ROW_USED-1:0], bus.sd_addr[7:0]};

    assign s1_word = {s1_dqm[1] ? 8'h00 : rd_hi,
                      s1_dqm[0] ? 8'h00 : rd_lo};

    always_comb begin
        is_act    = 1'b0;
        is_rd     = 1'b0;
        is_wr     = 1'b0;
        is_pre    = 1'b0;
        is_ref    = 1'b0;
        is_lmr    = 1'b0;
        case (cmd)
            CMD_ACT: is_act = 1'b1;
            CMD_RD:  is_rd  = 1'b1;
            CMD_WR:  is_wr  = 1'b1;
            CMD_PRE: is_pre = 1'b1;
            CMD_REF: is_ref = 1'b1;
            CMD_LMR: is_lmr = 1'b1;
            default: ;
        endcase
        bank_open = open_q[bank];
        cl_ok     = (mode_reg[6:4] == 3'd2) || (mode_reg[6:4] == 3'd3);
        do_act    = is_act && initialized;
        do_rd     = is_rd && initialized && bank_open;
        do_wr     = is_wr && initialized && bank_open;
        err_set   = 1'b0;
        if ((is_act || is_rd || is_wr) && !initialized)
            err_set = 1'b1;
        if ((is_rd || is_wr) && initialized && !bank_open)
            err_set = 1'b1;
        if (do_act && bank_open)
            err_set = 1'b1;
        if (do_rd && !cl_ok)
            err_set = 1'b1;
        // Write landing while a read is still in the CAS pipeline.
        if (do_wr && (s1_v || s2_v))
            err_set = 1'b1;
        if (is_ref && (|open_q))
            err_set = 1'b1;
        if (is_lmr && ((|open_q) || (bus.sd_addr[2:0] != 3'b000)))
            err_set = 1'b1;
    end

    // Read-before-write port: a write on the next edge cannot disturb
    // the word captured for an earlier read.
    always_ff @(posedge clk) begin
        if (do_wr && !reset && !bus.sd_dqm[1])
            mem_hi[idx] <= bus.dq_in[15:8];
        if (do_wr && !reset && !bus.sd_dqm[0])
            mem_lo[idx] <= bus.dq_in[7:0];
        rd_hi <= mem_hi[idx];
        rd_lo <= mem_lo[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dq_out    <= 16'h0000;
            bus.dq_oe     <= 1'b0;
            mode_reg      <= 12'h000;
            initialized   <= 1'b0;
            refresh_count <= 16'h0000;
            err           <= 1'b0;
            open_q        <= 4'b0000;
            pre_seen      <= 1'b0;
            init_cnt      <= 4'd0;
            s1_v          <= 1'b0;
            s1_cl3        <= 1'b0;
            s1_dqm        <= 2'b00;
            s2_v          <= 1'b0;
            s2_data       <= 16'h0000;
        end else begin
            if (err_set)
                err <= 1'b1;

            s1_v    <= do_rd;
            s1_cl3  <= (mode_reg[6:4] == 3'd3);
            s1_dqm  <= bus.sd_dqm;
            s2_v    <= s1_v && s1_cl3;
            s2_data <= s1_word;

            if (s2_v) begin
                bus.dq_oe  <= 1'b1;
                bus.dq_out <= s2_data;
            end else if (s1_v && !s1_cl3) begin
                bus.dq_oe  <= 1'b1;
                bus.dq_out <= s1_word;
            end else begin
                bus.dq_oe  <= 1'b0;
                bus.dq_out <= 16'h0000;
            end

            if (do_act) begin
                open_q[bank] <= 1'b1;
                row_q[bank]  <= bus.sd_addr;
            end
            if ((do_rd || do_wr) && a10)
                open_q[bank] <= 1'b0;
            if (is_pre) begin
                if (a10) begin
                    open_q   <= 4'b0000;
                    pre_seen <= 1'b1;
                end else begin
                    open_q[bank] <= 1'b0;
                end
            end
            if (is_ref) begin
                refresh_count <= refresh_count + 16'd1;
                if (init_cnt != 4'd15)
                    init_cnt <= init_cnt + 4'd1;
            end
            if (is_lmr) begin
                mode_reg <= bus.sd_addr;
                if (pre_seen && (init_cnt >= INIT_MIN))
                    initialized <= 1'b1;
            end
        end
    end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable SDR SDRAM device emulator: the target end of the 16-bit single-access SDRAM command bus driven by the team's SDRAM controllers.
- Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows and the mode register, and serves reads and writes from an internal block-RAM array with the programmed CAS latency.
- Used in loopback test builds and on boards without SDRAM, where a core's controller talks to FPGA block RAM over an unchanged interface.

Parameters:
- ROW_USED, 2, low row-address bits stored. Array index = {ba, row[ROW_USED-1:0], col[7:0]}. Higher row bits alias.
- INIT_REFRESH, 2, minimum AUTO_REFRESH commands required before LOAD_MODE completes initialization.

Ports:
- clk  in  1  clock, same edge the controller launches commands on
- reset  in  1  synchronous, active-high
- sd_cs, sd_ras, sd_cas, sd_we  in  1 each  active-low command pins; cmd = {cs,ras,cas,we}
- sd_addr  in  12  row/column/mode address; A10 = precharge-all or auto-precharge
- sd_ba  in  2  bank select
- sd_dqm  in  2  byte masks, [1]=high byte, 1=masked
- dq_in  in  16  write data from controller
- dq_out  out  16  read data to controller
- dq_oe  out  1  read data valid / drive enable for the top-level tristate
- mode_reg  out  12  last value loaded by LOAD_MODE
- initialized  out  1  init sequence complete
- refresh_count  out  16  AUTO_REFRESH commands seen, wraps
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: dq_out=0, dq_oe=0, mode_reg=0, initialized=0, refresh_count=0, err=0. All banks closed; read pipeline flushed; internal precharge-seen flag and refresh counter cleared. Array contents retained. Reset mid-read cancels pending data (dq_oe stays 0).
- All pins sampled on the rising clk edge. 1111 INHIBIT and 0111 NOP do nothing. Undecoded 0110 BURST_TERMINATE is ignored.
- Init sequence:
  - PRECHARGE with A10=1 sets precharge-seen.
  - Each AUTO_REFRESH increments the init counter, saturating at 15.
  - LOAD_MODE with precharge-seen and init counter >= INIT_REFRESH sets initialized=1.
  - LOAD_MODE always loads mode_reg, whether or not initialized is set.
  - Before initialized, ACTIVE/READ/WRITE set err and are ignored.
- ACTIVE 0011: opens bank ba with row sd_addr. If the bank is already open: err=1 and the row is replaced.
- READ 0101 at edge E:
  - Bank closed: err=1, no data.
  - Otherwise address the array with open row and col=sd_addr[7:0]. DQM is sampled at E.
  - dq_out/dq_oe update at edge E+CL-1, hold for one clock, return to dq_oe=0 (dq_out 0) the next edge.
  - Masked bytes read as 8'h00.
  - CL = mode_reg[6:4]; 2 or 3 valid, any other value is treated as 2 and sets err on the READ.
  - Back-to-back READs are fully pipelined, one word per cycle.
- WRITE 0100 at edge E: bank must be open, else err=1 and nothing written. dq_in is written at E with byte enables ~sd_dqm.
- WRITE while a READ result is pending: the write executes, the pending read still outputs, err=1.
- READ/WRITE with A10=1 (auto-precharge) closes the bank after the access.
- A read followed by a write to the same word in the next cycle returns the old data.
- PRECHARGE 0010: A10=1 closes all banks; else closes bank ba. Closing an already-closed bank is legal.
- AUTO_REFRESH 0001: refresh_count+1 (wraps 16'hFFFF->0). If any bank is open: err=1, banks remain open.
- LOAD_MODE 0000 with any bank open: err=1, mode still loaded.
- mode_reg[2:0] != 000 (burst): err=1 at load; accesses stay single-word.
- mode_reg[9] (write-burst bit) is ignored.

Test Plan:
- Init: PRECHARGE A10=1, 2x AUTO_REFRESH, LOAD_MODE 12'h220 -> initialized=1, mode_reg=12'h220, refresh_count=2, err=0.
- CL2 access: ACTIVE ba=1 row=3; WRITE col 8'h5A, dq_in=16'hBEEF, dqm=00; READ col 8'h5A at edge E -> dq_oe=1 and dq_out=16'hBEEF only in the cycle after edge E+1.
- Byte masks and aliasing:
  - WRITE 16'h1234 dqm=10 over 16'hBEEF -> read back 16'hBE34.
  - READ with dqm=01 -> 16'hBE00.
  - row 3 vs row 7 with ROW_USED=2 alias to the same word.
- CL3 and pipelining: LOAD_MODE 12'h230; READs at E, E+1 to two written words -> data at edges E+2, E+3, dq_oe high exactly two cycles.
- Errors:
  - READ to a closed bank.
  - ACTIVE before init.
  - AUTO_REFRESH with a bank open.
  - Each sets err, which stays 1 until reset; no array change, no dq_oe.
- Auto-precharge and reset: READ with A10=1 then READ without ACTIVE -> err. Assert reset at edge E+1 of a CL3 read -> dq_oe never rises, prior array data intact after re-init.
